// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, holds a
// one-entry skid buffer while decode stalls, and loads the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [1:0]  id_imm_sel
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    function automatic logic [1:0] imm_sel_of(input logic [31:0] instr);
        logic [1:0] sel;
        sel = 2'b00;
        case (instr[6:0])
            7'b0100011: sel = 2'b01;
            7'b1100011: sel = 2'b10;
            7'b1101111: sel = 2'b11;
            default:    sel = 2'b00;
        endcase
        return sel;
    endfunction

    // Request is gated by rst so it drops the moment reset asserts.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'h0;
            id_imm_sel <= 2'b00;
        end else if (redirect) begin
            state      <= FETCH;
            pc         <= {redirect_pc[31:2], 2'b00};
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_imm_sel <= 2'b00;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready && !stall) begin
                        id_valid   <= 1'b1;
                        id_instr   <= imem_rdata;
                        id_pc      <= pc;
                        id_imm_sel <= imm_sel_of(imem_rdata);
                        pc         <= pc + 32'd4;
                    end else if (imem_ready && stall) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc;
                        state      <= HOLD;
                    end else if (!imem_ready && !stall) begin
                        id_valid   <= 1'b0;
                        id_instr   <= NOP_INSTR;
                        id_imm_sel <= 2'b00;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid   <= 1'b1;
                        id_instr   <= skid_instr;
                        id_pc      <= skid_pc;
                        id_imm_sel <= imm_sel_of(skid_instr);
                        pc         <= pc + 32'd4;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word presented on an invalid IF/ID slot.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals current PC.
REQ-007 imem_ready  input  1  imem_rdata valid this cycle for the outstanding request.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-010 redirect  input  1  taken branch/jump; restart fetch at redirect_pc.
REQ-011 redirect_pc  input  32  redirect target address.
REQ-012 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 id_instr  output  32  IF/ID instruction word; bits [31:7] feed the immediate generator.
REQ-014 id_pc  output  32  address of id_instr.
REQ-015 id_imm_sel  output  2  immediate-format select for id_instr: 00 I, 01 S, 10 B, 11 J.

Function
REQ-016 States: FETCH (request outstanding) and HOLD (word captured in skid buffer, waiting on stall).
REQ-017 imem_req SHALL be 1 exactly when state is FETCH and rst is 0; imem_addr SHALL equal pc in every cycle.
REQ-018 FETCH, imem_ready=1, stall=0: IF/ID <- {valid=1, imem_rdata, pc, decoded sel}; pc <- pc+4 (mod 2^32); stay FETCH.
REQ-019 FETCH, imem_ready=1, stall=1: imem_rdata and pc captured in skid buffer; IF/ID unchanged; pc unchanged; go HOLD.
REQ-020 FETCH, imem_ready=0, stall=0: id_valid <- 0, id_instr <- NOP_INSTR, id_imm_sel <- 00 (bubble); id_pc unchanged.
REQ-021 FETCH, imem_ready=0, stall=1: all IF/ID fields and pc unchanged.
REQ-022 HOLD, stall=1: no change; imem_ready ignored.
REQ-023 HOLD, stall=0: IF/ID <- skid buffer contents with valid=1; pc <- pc+4; go FETCH; request reissues next cycle at new pc.
REQ-024 redirect=1 SHALL take priority over every other condition in either state: pc <- {redirect_pc[31:2], 2'b00}; id_valid <- 0; id_instr <- NOP_INSTR; id_imm_sel <- 00; skid buffer discarded; state <- FETCH; same-cycle imem_ready/imem_rdata ignored; stall ignored.
REQ-025 id_imm_sel decode from opcode bits [6:0] of the word loaded: 0000011, 0010011, 1100111 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other opcode -> 00.
REQ-026 id_imm_sel SHALL be registered in the same edge as id_instr; never combinational from id_instr.
REQ-027 Fetch latency: word returned with imem_ready in cycle N appears on id_* after edge N when stall=0.
REQ-028 pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Reset
REQ-029 rst=1 SHALL immediately, without clock: pc=RESET_PC, state=FETCH, id_valid=0, id_instr=NOP_INSTR, id_pc=32'h0, id_imm_sel=00, skid buffer cleared, imem_req=0.
REQ-030 Reset asserted mid-HOLD or mid-request SHALL discard captured word; first request after release SHALL be at RESET_PC.
REQ-031 On the first edge after rst release with imem_ready=1, stall=0: id_pc=RESET_PC, id_valid=1.

Verification
REQ-032 Reset release, imem_ready=1 always, rdata=32'h00500093 -> id_pc 0,4,8 on consecutive edges, id_imm_sel=00, id_valid=1.
REQ-033 FETCH at pc=8, ready=1 with rdata=32'h00112023, stall=1 for 3 cycles -> imem_req=0 in HOLD, IF/ID frozen; stall drop -> id_instr=32'h00112023, id_pc=8, id_imm_sel=01, next imem_addr=12.
REQ-034 redirect=1, redirect_pc=32'h0000_0103 while in HOLD with stall=1 -> next cycle id_valid=0, id_instr=NOP_INSTR, imem_addr=32'h0000_0100, state FETCH.
REQ-035 imem_ready=0 for 2 cycles, stall=0 -> two bubbles (id_valid=0); then rdata=32'h0000006F -> id_imm_sel=11; rdata=32'hFE000EE3 -> id_imm_sel=10.
REQ-036 rst pulse between clock edges while in HOLD -> outputs reset values immediately; pc=RESET_PC; pc=32'hFFFF_FFFC fetch with ready=1 -> next imem_addr=32'h0.
